// File: rtl/instruction_fetch_queue.sv
// Dual-issue fetch: own PC, paired reads from a 1-cycle memory into a DEPTH-entry queue, 2 instr/cycle to decode.
// Request-to-decode latency 2 cycles; requests stall on queue space, decode back-pressures through consume.
module instruction_fetch_queue #(
   parameter int                  PC_WIDTH    = 11,
   parameter int                  INSTR_WIDTH = 32,
   parameter int                  DEPTH       = 8,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   PC_source,
   input  logic [PC_WIDTH-1:0]    PC_jump,
   input  logic                   IF_flush,
   input  logic [1:0]             consume,
   output logic                   mem_req,
   output logic [PC_WIDTH-1:0]    mem_addr,
   input  logic [INSTR_WIDTH-1:0] mem_rdata1,
   input  logic [INSTR_WIDTH-1:0] mem_rdata2,
   output logic [INSTR_WIDTH-1:0] fetch_output1,
   output logic [INSTR_WIDTH-1:0] fetch_output2,
   output logic                   fetch_valid1,
   output logic                   fetch_valid2,
   output logic [PC_WIDTH-1:0]    fetch_pc1,
   output logic [PC_WIDTH-1:0]    PC_adderOut
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SUM_W = CNT_W + 2;

   typedef struct packed {
      logic [INSTR_WIDTH-1:0] instr;
      logic [PC_WIDTH-1:0]    pc;
   } entry_t;

   entry_t              queue_mem [DEPTH];
   entry_t              head1;
   entry_t              head2;
   logic [PTR_W-1:0]    rd_ptr;
   logic [PTR_W-1:0]    rd_ptr_p1;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    wr_ptr_p1;
   logic [CNT_W-1:0]    count;
   logic                pending;
   logic [PC_WIDTH-1:0] pc;
   logic [PC_WIDTH-1:0] req_pc;
   logic                clear;
   logic                wr_en;
   logic [1:0]          taken;
   logic [SUM_W-1:0]    need;
   logic [SUM_W-1:0]    avail;

   assign clear     = PC_source | IF_flush;
   assign wr_en     = pending & ~clear;
   assign rd_ptr_p1 = rd_ptr + PTR_W'(1);
   assign wr_ptr_p1 = wr_ptr + PTR_W'(1);

   // Decode can never take more than is queued, nor more than two per cycle.
   always_comb begin
      taken = consume;
      if (consume == 2'd3) begin
         taken = 2'd2;
      end
      if (count == '0) begin
         taken = 2'd0;
      end else if ((count == CNT_W'(1)) && (taken > 2'd1)) begin
         taken = 2'd1;
      end
   end

   // Space left after the in-flight pair lands and this cycle's reads leave must fit a new pair.
   always_comb begin
      need  = SUM_W'(count) + (pending ? SUM_W'(4) : SUM_W'(2));
      avail = SUM_W'(DEPTH) + SUM_W'(taken);
   end

   assign mem_req     = ~reset & ~clear & (need <= avail);
   assign mem_addr    = pc;
   assign PC_adderOut = pc + PC_WIDTH'(2);

   always_ff @(posedge clk) begin
      if (reset) begin
         pc      <= RESET_PC;
         req_pc  <= '0;
         pending <= 1'b0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else if (clear) begin
         if (PC_source) begin
            pc <= PC_jump;
         end
         pending <= 1'b0;
         rd_ptr  <= '0;
         wr_ptr  <= '0;
         count   <= '0;
      end else begin
         pending <= mem_req;
         if (mem_req) begin
            pc     <= pc + PC_WIDTH'(2);
            req_pc <= pc;
         end
         rd_ptr <= rd_ptr + PTR_W'(taken);
         if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(2);
         end
         count <= count - CNT_W'(taken) + (wr_en ? CNT_W'(2) : CNT_W'(0));
      end
   end

   // Payload storage needs no reset: outputs are masked by count.
   always_ff @(posedge clk) begin
      if (wr_en && !reset) begin
         queue_mem[wr_ptr]    <= '{instr: mem_rdata1, pc: req_pc};
         queue_mem[wr_ptr_p1] <= '{instr: mem_rdata2, pc: req_pc + PC_WIDTH'(1)};
      end
   end

   assign head1 = queue_mem[rd_ptr];
   assign head2 = queue_mem[rd_ptr_p1];

   assign fetch_valid1  = (count != '0);
   assign fetch_valid2  = (count >= CNT_W'(2));
   assign fetch_output1 = fetch_valid1 ? head1.instr : '0;
   assign fetch_output2 = fetch_valid2 ? head2.instr : '0;
   assign fetch_pc1     = fetch_valid1 ? head1.pc : '0;

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// Directed bench for instruction_fetch_queue: memory returns instr == address.
module tb_instruction_fetch_queue;

   logic        clk = 1'b0;
   logic        reset;
   logic        PC_source;
   logic [10:0] PC_jump;
   logic        IF_flush;
   logic [1:0]  consume;
   logic        mem_req;
   logic [10:0] mem_addr;
   logic [31:0] mem_rdata1 = '0;
   logic [31:0] mem_rdata2 = '0;
   logic [31:0] fetch_output1;
   logic [31:0] fetch_output2;
   logic        fetch_valid1;
   logic        fetch_valid2;
   logic [10:0] fetch_pc1;
   logic [10:0] PC_adderOut;

   int errors = 0;
   int checks = 0;
   int max_count = 0;

   instruction_fetch_queue #(
      .PC_WIDTH(11), .INSTR_WIDTH(32), .DEPTH(8), .RESET_PC(11'd0)
   ) dut (
      .clk(clk), .reset(reset), .PC_source(PC_source), .PC_jump(PC_jump),
      .IF_flush(IF_flush), .consume(consume), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_rdata1(mem_rdata1), .mem_rdata2(mem_rdata2),
      .fetch_output1(fetch_output1), .fetch_output2(fetch_output2),
      .fetch_valid1(fetch_valid1), .fetch_valid2(fetch_valid2),
      .fetch_pc1(fetch_pc1), .PC_adderOut(PC_adderOut)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] word(input logic [10:0] a);
      return {21'd0, a};
   endfunction

   always @(posedge clk) begin
      if (mem_req) begin
         mem_rdata1 <= word(mem_addr);
         mem_rdata2 <= word(mem_addr + 11'd1);
      end
   end

   always @(negedge clk) begin
      if (int'(dut.count) > max_count) max_count = int'(dut.count);
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; PC_source = 1'b0; IF_flush = 1'b0; consume = 2'd0; PC_jump = '0;
      cyc();
      cyc();
      reset = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1; PC_source = 1'b1; PC_jump = 11'h155; IF_flush = 1'b0; consume = 2'd2;
      cyc();
      cyc();
      #1;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL reset mem_req got=%0b exp=0", mem_req); end checks++;
      if (fetch_valid1 !== 1'b0) begin errors++; $display("FAIL reset valid1 got=%0b exp=0", fetch_valid1); end checks++;
      if (fetch_valid2 !== 1'b0) begin errors++; $display("FAIL reset valid2 got=%0b exp=0", fetch_valid2); end checks++;
      if (fetch_output1 !== 32'd0) begin errors++; $display("FAIL reset out1 got=%h exp=0", fetch_output1); end checks++;
      if (fetch_output2 !== 32'd0) begin errors++; $display("FAIL reset out2 got=%h exp=0", fetch_output2); end checks++;
      if (fetch_pc1 !== 11'd0) begin errors++; $display("FAIL reset pc1 got=%h exp=0", fetch_pc1); end checks++;
      if (PC_adderOut !== 11'd2) begin errors++; $display("FAIL reset adder got=%h exp=2", PC_adderOut); end checks++;
      PC_source = 1'b0; consume = 2'd0;
   endtask

   task automatic test_stream();
      logic [10:0] e;
      do_reset();
      consume = 2'd2;
      #1;
      if (mem_req !== 1'b1 || mem_addr !== 11'd0) begin errors++; $display("FAIL stream c0 req/addr got=%0b/%h exp=1/0", mem_req, mem_addr); end checks++;
      if (fetch_valid1 !== 1'b0) begin errors++; $display("FAIL stream c0 valid1 got=%0b exp=0", fetch_valid1); end checks++;
      cyc();
      #1;
      if (mem_addr !== 11'd2 || fetch_valid1 !== 1'b0) begin errors++; $display("FAIL stream c1 addr/valid1 got=%h/%0b exp=2/0", mem_addr, fetch_valid1); end checks++;
      for (int c = 2; c < 10; c++) begin
         cyc();
         #1;
         e = 11'(2 * (c - 2));
         if (mem_req !== 1'b1 || mem_addr !== 11'(2 * c)) begin errors++; $display("FAIL stream c%0d req/addr got=%0b/%h exp=1/%h", c, mem_req, mem_addr, 11'(2 * c)); end checks++;
         if (fetch_valid1 !== 1'b1 || fetch_valid2 !== 1'b1) begin errors++; $display("FAIL stream c%0d valids got=%0b%0b exp=11", c, fetch_valid1, fetch_valid2); end checks++;
         if (fetch_output1 !== word(e) || fetch_output2 !== word(e + 11'd1) || fetch_pc1 !== e) begin
            errors++; $display("FAIL stream c%0d out1/out2/pc1 got=%h/%h/%h exp=%h/%h/%h", c, fetch_output1, fetch_output2, fetch_pc1, word(e), word(e + 11'd1), e);
         end checks++;
      end
   endtask

   task automatic test_backpressure();
      int exp_req [11] = '{1, 1, 1, 1, 0, 0, 0, 1, 0, 1, 0};
      int exp_addr[11] = '{0, 2, 4, 6, 0, 0, 0, 8, 0, 10, 0};
      int exp_o1  [11] = '{-1, -1, 0, 0, 0, 0, 0, 1, 2, 3, 4};
      int e;
      do_reset();
      for (int c = 0; c < 11; c++) begin
         if (c > 0) cyc();
         consume = (c >= 6) ? 2'd1 : 2'd0;
         #1;
         if (mem_req !== 1'(exp_req[c])) begin errors++; $display("FAIL bp c%0d mem_req got=%0b exp=%0d", c, mem_req, exp_req[c]); end checks++;
         if (exp_req[c] == 1) begin
            if (mem_addr !== 11'(exp_addr[c])) begin errors++; $display("FAIL bp c%0d addr got=%h exp=%h", c, mem_addr, exp_addr[c]); end checks++;
         end
         if (fetch_valid1 !== (exp_o1[c] >= 0)) begin errors++; $display("FAIL bp c%0d valid1 got=%0b exp=%0b", c, fetch_valid1, exp_o1[c] >= 0); end checks++;
         if (exp_o1[c] >= 0) begin
            if (fetch_output1 !== 32'(exp_o1[c]) || fetch_pc1 !== 11'(exp_o1[c])) begin errors++; $display("FAIL bp c%0d out1/pc1 got=%h/%h exp=%h", c, fetch_output1, fetch_pc1, exp_o1[c]); end checks++;
         end
      end
      e = 5;
      for (int c = 11; c < 17; c++) begin
         cyc();
         consume = 2'd2;
         #1;
         if (fetch_valid2 !== 1'b1 || fetch_output1 !== 32'(e) || fetch_output2 !== 32'(e + 1)) begin
            errors++; $display("FAIL bp drain c%0d v2/out1/out2 got=%0b/%h/%h exp=1/%h/%h", c, fetch_valid2, fetch_output1, fetch_output2, e, e + 1);
         end checks++;
         e += 2;
      end
   endtask

   task automatic test_redirect();
      do_reset();
      consume = 2'd2;
      repeat (8) cyc();
      #1;
      if (mem_addr !== 11'h010) begin errors++; $display("FAIL redir setup addr got=%h exp=010", mem_addr); end checks++;
      cyc();
      PC_source = 1'b1; PC_jump = 11'h155;
      #1;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL redir c9 mem_req got=%0b exp=0", mem_req); end checks++;
      cyc();
      PC_source = 1'b0;
      #1;
      if (fetch_valid1 !== 1'b0 || fetch_valid2 !== 1'b0 || fetch_output1 !== 32'd0) begin errors++; $display("FAIL redir c10 v1/v2/out1 got=%0b/%0b/%h exp=0/0/0", fetch_valid1, fetch_valid2, fetch_output1); end checks++;
      if (mem_req !== 1'b1 || mem_addr !== 11'h155 || PC_adderOut !== 11'h157) begin errors++; $display("FAIL redir c10 req/addr/adder got=%0b/%h/%h exp=1/155/157", mem_req, mem_addr, PC_adderOut); end checks++;
      cyc();
      #1;
      if (fetch_valid1 !== 1'b0 || mem_addr !== 11'h157) begin errors++; $display("FAIL redir c11 v1/addr got=%0b/%h exp=0/157", fetch_valid1, mem_addr); end checks++;
      cyc();
      #1;
      if (fetch_valid1 !== 1'b1 || fetch_valid2 !== 1'b1 || fetch_output1 !== 32'h155 || fetch_output2 !== 32'h156 || fetch_pc1 !== 11'h155) begin
         errors++; $display("FAIL redir c12 v/out1/out2/pc1 got=%0b%0b/%h/%h/%h exp=11/155/156/155", fetch_valid1, fetch_valid2, fetch_output1, fetch_output2, fetch_pc1);
      end checks++;
   endtask

   task automatic test_flush();
      do_reset();
      cyc();
      cyc();
      cyc();
      consume = 2'd1;
      cyc();
      consume = 2'd0; IF_flush = 1'b1;
      #1;
      if (mem_req !== 1'b0 || fetch_valid2 !== 1'b1 || fetch_output1 !== 32'd1) begin errors++; $display("FAIL flush c4 req/v2/out1 got=%0b/%0b/%h exp=0/1/1", mem_req, fetch_valid2, fetch_output1); end checks++;
      cyc();
      IF_flush = 1'b0;
      #1;
      if (fetch_valid1 !== 1'b0 || fetch_valid2 !== 1'b0) begin errors++; $display("FAIL flush c5 valids got=%0b%0b exp=00", fetch_valid1, fetch_valid2); end checks++;
      if (mem_req !== 1'b1 || mem_addr !== 11'd8) begin errors++; $display("FAIL flush c5 req/addr got=%0b/%h exp=1/8", mem_req, mem_addr); end checks++;
      cyc();
      #1;
      if (fetch_valid1 !== 1'b0 || mem_addr !== 11'd10) begin errors++; $display("FAIL flush c6 v1/addr got=%0b/%h exp=0/a", fetch_valid1, mem_addr); end checks++;
      cyc();
      #1;
      if (fetch_valid1 !== 1'b1 || fetch_output1 !== 32'd8 || fetch_output2 !== 32'd9 || fetch_pc1 !== 11'd8) begin
         errors++; $display("FAIL flush c7 v1/out1/out2/pc1 got=%0b/%h/%h/%h exp=1/8/9/8", fetch_valid1, fetch_output1, fetch_output2, fetch_pc1);
      end checks++;
   endtask

   task automatic test_wrap();
      do_reset();
      consume = 2'd2; PC_source = 1'b1; PC_jump = 11'h7FF;
      #1;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL wrap c0 mem_req got=%0b exp=0", mem_req); end checks++;
      cyc();
      PC_source = 1'b0;
      #1;
      if (mem_req !== 1'b1 || mem_addr !== 11'h7FF || PC_adderOut !== 11'h001) begin errors++; $display("FAIL wrap c1 req/addr/adder got=%0b/%h/%h exp=1/7ff/001", mem_req, mem_addr, PC_adderOut); end checks++;
      cyc();
      #1;
      if (mem_addr !== 11'h001 || PC_adderOut !== 11'h003 || fetch_valid1 !== 1'b0) begin errors++; $display("FAIL wrap c2 addr/adder/v1 got=%h/%h/%0b exp=001/003/0", mem_addr, PC_adderOut, fetch_valid1); end checks++;
      cyc();
      #1;
      if (fetch_valid2 !== 1'b1 || fetch_output1 !== 32'h7FF || fetch_output2 !== 32'h000 || fetch_pc1 !== 11'h7FF) begin
         errors++; $display("FAIL wrap c3 v2/out1/out2/pc1 got=%0b/%h/%h/%h exp=1/7ff/0/7ff", fetch_valid2, fetch_output1, fetch_output2, fetch_pc1);
      end checks++;
      cyc();
      #1;
      if (fetch_output1 !== 32'h001 || fetch_output2 !== 32'h002 || fetch_pc1 !== 11'h001) begin errors++; $display("FAIL wrap c4 out1/out2/pc1 got=%h/%h/%h exp=1/2/1", fetch_output1, fetch_output2, fetch_pc1); end checks++;
   endtask

   task automatic test_reset_midfetch();
      do_reset();
      consume = 2'd2;
      cyc();
      cyc();
      reset = 1'b1;
      #1;
      if (mem_req !== 1'b0) begin errors++; $display("FAIL rstmid c2 mem_req got=%0b exp=0", mem_req); end checks++;
      cyc();
      reset = 1'b0;
      #1;
      if (fetch_valid1 !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 11'd0) begin errors++; $display("FAIL rstmid c3 v1/req/addr got=%0b/%0b/%h exp=0/1/0", fetch_valid1, mem_req, mem_addr); end checks++;
      cyc();
      #1;
      if (fetch_valid1 !== 1'b0 || mem_addr !== 11'd2) begin errors++; $display("FAIL rstmid c4 v1/addr got=%0b/%h exp=0/2", fetch_valid1, mem_addr); end checks++;
      cyc();
      #1;
      if (fetch_valid1 !== 1'b1 || fetch_output1 !== 32'd0 || fetch_output2 !== 32'd1 || fetch_pc1 !== 11'd0) begin
         errors++; $display("FAIL rstmid c5 v1/out1/out2/pc1 got=%0b/%h/%h/%h exp=1/0/1/0", fetch_valid1, fetch_output1, fetch_output2, fetch_pc1);
      end checks++;
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect();
      test_flush();
      test_wrap();
      test_reset_midfetch();
      if (max_count != 8) begin errors++; $display("FAIL max_occupancy got=%0d exp=8", max_count); end checks++;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instruction_fetch_queue.md
Name: instruction_fetch_queue

Overview:
Parametrised dual-issue fetch stage that replaces the single-register fetch path. It runs its own PC and issues paired-instruction requests to a synchronous instruction memory with 1-cycle read latency. Returned pairs are buffered in a DEPTH-entry FIFO, and up to two instructions per cycle are presented to decode. Supports redirect (jump/branch) with squash of in-flight fetches, a flush-only mode, and decode back-pressure via a consume count.

Parameters:
PC_WIDTH, 11, width of PC / instruction address (instruction-granular addressing)
INSTR_WIDTH, 32, width of one instruction
DEPTH, 8, FIFO entries; power of two, >= 4
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high
PC_source  in  1  1 = redirect fetch to PC_jump this cycle
PC_jump  in  PC_WIDTH  redirect target
IF_flush  in  1  clear FIFO and squash in-flight fetch; PC not changed
consume  in  2  instructions taken by decode this cycle (0..2)
mem_req  out  1  read request valid
mem_addr  out  PC_WIDTH  read address; memory returns instr at addr and addr+1
mem_rdata1  in  INSTR_WIDTH  instr at mem_addr of previous cycle
mem_rdata2  in  INSTR_WIDTH  instr at mem_addr+1 of previous cycle
fetch_output1  out  INSTR_WIDTH  oldest queued instr; 0 when fetch_valid1=0
fetch_output2  out  INSTR_WIDTH  second-oldest queued instr; 0 when fetch_valid2=0
fetch_valid1  out  1  fetch_output1 valid
fetch_valid2  out  1  fetch_output2 valid (implies fetch_valid1)
fetch_pc1  out  PC_WIDTH  PC of fetch_output1
PC_adderOut  out  PC_WIDTH  current fetch PC + 2 (mod 2^PC_WIDTH)

Behaviour:
- Reset: PC=RESET_PC, FIFO empty (count=0), pending=0, mem_req=0, fetch_valid1/2=0, fetch_output1/2=0, fetch_pc1=0.
- The FIFO stores {instr, pc} per entry. count is in 0..DEPTH. Read/write pointers wrap mod DEPTH.
- Request rule: mem_req = !reset && !PC_source && !IF_flush && (DEPTH - count - 2*pending + taken >= 2), where taken = min(consume, count). mem_addr = PC. On request, PC <= PC+2 (wraps modulo 2^PC_WIDTH) and pending <= 1; otherwise pending <= 0.
- Response: the cycle after a request with pending=1, both mem_rdata words are written to the FIFO with pcs PC_req and PC_req+1. Latency from request to fetch_valid1 = 2 cycles when the FIFO is empty.
- Outputs are combinational from FIFO head: valid1 = count>=1, valid2 = count>=2.
- consume is clamped to count. consume=2 with count=1 removes 1. Read and write in the same cycle are both honoured; count_next = count - taken + 2*write.
- The request rule guarantees no overflow. The bench asserts count never exceeds DEPTH.
- Redirect (PC_source=1): FIFO cleared, pending squashed (the next-cycle response is discarded), PC <= PC_jump, no request this cycle. consume is ignored. Fetch resumes the next cycle at PC_jump.
- IF_flush=1 with PC_source=0: FIFO cleared, pending squashed, PC unchanged, no request this cycle.
- PC_source and IF_flush both high: behaves as redirect.
- reset dominates all inputs. Reset asserted mid-fetch discards the in-flight response.
- Odd PC_jump is legal. Pairs are unaligned and the sequence continues PC_jump, PC_jump+1, PC_jump+2, ...

Test Plan:
- Reset then free-run with consume=2, mem returns instr=addr: mem_addr 0,2,4,... each cycle. fetch_valid1/2 first high on cycle 2 with outputs 0,1 and fetch_pc1=0. A steady 2 instr/cycle stream follows.
- consume=0 held, DEPTH=8: exactly 4 requests issue (addrs 0,2,4,6), count reaches 8, mem_req stays 0. Then consume=1: mem_req reasserts only once count+pending space >= 2. No entry is lost or duplicated.
- Redirect PC_source=1, PC_jump=0x155 while a request to 0x010 is pending: the 0x010 response is dropped and outputs go invalid next cycle. The next mem_addr is 0x155, and the first valid pair is 0x155/0x156 with fetch_pc1=0x155.
- IF_flush=1 pulse with count=5: all valids drop next cycle. The PC continues from its pre-flush value, with no redirect.
- PC wrap: PC_jump=0x7FF: the request returns instrs at 0x7FF and 0x000, and the following mem_addr is 0x001. PC_adderOut shows 0x001 while the PC is 0x7FF.
- consume=2 with count=1, and reset asserted while pending=1: count goes to 0 without underflow. After reset, no stale entry appears and mem_addr restarts at RESET_PC.
